// File: rtl/avsdpll_lock_ctrl_if.sv
// Signal bundle between the avsdpll lock controller and its environment.
// The controller is the slave side: it takes START/DIV_SEL plus the two
// asynchronous PLL observations and returns enables, divider select and status.
interface avsdpll_lock_ctrl_if;
    logic       START;
    logic [3:0] DIV_SEL;
    logic       REF;
    logic       PLL_CLK;
    logic       EN_CP;
    logic       EN_VCO;
    logic [3:0] B;
    logic       LOCK;
    logic       FAIL;
    logic [7:0] MEAS;
    logic [2:0] STATE;

    modport master (
        output START, DIV_SEL, REF, PLL_CLK,
        input  EN_CP, EN_VCO, B, LOCK, FAIL, MEAS, STATE
    );

    modport slave (
        input  START, DIV_SEL, REF, PLL_CLK,
        output EN_CP, EN_VCO, B, LOCK, FAIL, MEAS, STATE
    );
endinterface

// File: rtl/avsdpll_lock_ctrl.sv
// Bring-up sequencer and lock detector for the avsdpll macro.
// Powers up charge pump then VCO, then counts PLL_CLK rises per REF period
// and declares LOCK (or FAIL on acquisition timeout).
// Optional build macro AVSDPLL_REF_WATCHDOG_EN adds a dead-REF watchdog that
// turns a 4095-cycle REF silence into a bad window.
module avsdpll_lock_ctrl #(
    parameter int CP_SETTLE   = 16,
    parameter int VCO_SETTLE  = 64,
    parameter int TOL         = 1,
    parameter int LOCK_CNT    = 4,
    parameter int UNLOCK_CNT  = 2,
    parameter int ACQ_TIMEOUT = 64
) (
    input  logic                      CLK,
    input  logic                      RST,
    avsdpll_lock_ctrl_if.slave        bus
);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CP_ON   = 3'd1,
        ST_VCO_ON  = 3'd2,
        ST_ACQUIRE = 3'd3,
        ST_LOCKED  = 3'd4,
        ST_FAIL    = 3'd5
    } state_e;

    localparam logic signed [8:0] TOL_S = 9'(TOL);

    state_e      state_q, state_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  edge_cnt_q, edge_cnt_d;
    logic [7:0]  good_run_q, good_run_d;
    logic [7:0]  bad_run_q, bad_run_d;
    logic [7:0]  acq_win_q, acq_win_d;
    logic        win_open_q, win_open_d;
    logic [3:0]  b_q, b_d;
    logic [7:0]  meas_q, meas_d;
    logic        lock_q, lock_d;
    logic        fail_q, fail_d;
    logic        en_cp_q, en_cp_d;
    logic        en_vco_q, en_vco_d;
    logic [2:0]  ref_sync_q, ref_sync_d;
    logic [2:0]  pll_sync_q, pll_sync_d;
`ifdef AVSDPLL_REF_WATCHDOG_EN
    logic [11:0] wd_cnt_q, wd_cnt_d;
`endif

    logic               ref_rise_s;
    logic               pll_rise_s;
    logic signed [8:0]  dev_s;
    logic               win_good_s;
    logic               eval_s;
    logic               good_s;
    logic [7:0]         good_next_s;
    logic [7:0]         bad_next_s;
    logic [7:0]         acq_next_s;

    // Rise detection on the synchronized REF/PLL_CLK and the window quality test.
    always_comb begin
        ref_rise_s = ref_sync_q[1] & ~ref_sync_q[2];
        pll_rise_s = pll_sync_q[1] & ~pll_sync_q[2];
        dev_s      = $signed({1'b0, edge_cnt_q}) - $signed({5'd0, b_q});
        win_good_s = (dev_s <= TOL_S) && (dev_s >= -TOL_S);
    end

    // Next-state computation for the sequencer, window counters and outputs.
    always_comb begin
        state_d      = state_q;
        settle_cnt_d = settle_cnt_q;
        edge_cnt_d   = edge_cnt_q;
        good_run_d   = good_run_q;
        bad_run_d    = bad_run_q;
        acq_win_d    = acq_win_q;
        win_open_d   = win_open_q;
        b_d          = b_q;
        meas_d       = meas_q;
        lock_d       = lock_q;
        fail_d       = fail_q;
        en_cp_d      = en_cp_q;
        en_vco_d     = en_vco_q;
        ref_sync_d   = {ref_sync_q[1:0], bus.REF};
        pll_sync_d   = {pll_sync_q[1:0], bus.PLL_CLK};
        eval_s       = 1'b0;
        good_s       = 1'b0;
        good_next_s  = good_run_q + 8'd1;
        bad_next_s   = bad_run_q + 8'd1;
        acq_next_s   = acq_win_q + 8'd1;
`ifdef AVSDPLL_REF_WATCHDOG_EN
        wd_cnt_d     = wd_cnt_q;
`endif

        case (state_q)
            ST_IDLE: begin
                if (bus.START) begin
                    b_d          = bus.DIV_SEL;
                    settle_cnt_d = 8'd0;
                    if (bus.DIV_SEL == 4'd0) begin
                        state_d = ST_FAIL;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = ST_CP_ON;
                        en_cp_d = 1'b1;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end

            ST_CP_ON: begin
                if (settle_cnt_q == 8'(CP_SETTLE - 1)) begin
                    state_d      = ST_VCO_ON;
                    en_vco_d     = 1'b1;
                    settle_cnt_d = 8'd0;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end

            ST_VCO_ON: begin
                if (settle_cnt_q == 8'(VCO_SETTLE - 1)) begin
                    // The counter runs free before the first REF rise, so that
                    // rise only opens a window and the partial count is dropped.
                    state_d      = ST_ACQUIRE;
                    settle_cnt_d = 8'd0;
                    edge_cnt_d   = 8'd0;
                    win_open_d   = 1'b0;
                    good_run_d   = 8'd0;
                    bad_run_d    = 8'd0;
                    acq_win_d    = 8'd0;
`ifdef AVSDPLL_REF_WATCHDOG_EN
                    wd_cnt_d     = 12'd0;
`endif
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end

            ST_ACQUIRE, ST_LOCKED: begin
                // A PLL rise coinciding with the closing REF rise belongs to the new window.
                if (ref_rise_s) begin
                    edge_cnt_d = pll_rise_s ? 8'd1 : 8'd0;
                end else if (pll_rise_s && (edge_cnt_q != 8'd255)) begin
                    edge_cnt_d = edge_cnt_q + 8'd1;
                end else begin
                    edge_cnt_d = edge_cnt_q;
                end

                if (ref_rise_s) begin
                    win_open_d = 1'b1;
                    if (win_open_q) begin
                        eval_s = 1'b1;
                        good_s = win_good_s;
                        meas_d = edge_cnt_q;
                    end else begin
                        eval_s = 1'b0;
                    end
                end else begin
                    win_open_d = win_open_q;
                end

`ifdef AVSDPLL_REF_WATCHDOG_EN
                // REF silence for 4095 cycles is scored as a bad window and
                // restarts the count as if a window had just opened.
                if (ref_rise_s) begin
                    wd_cnt_d = 12'd0;
                end else if (wd_cnt_q == 12'd4095) begin
                    wd_cnt_d   = 12'd0;
                    eval_s     = 1'b1;
                    good_s     = 1'b0;
                    meas_d     = 8'd0;
                    edge_cnt_d = pll_rise_s ? 8'd1 : 8'd0;
                    win_open_d = 1'b1;
                end else begin
                    wd_cnt_d = wd_cnt_q + 12'd1;
                end
`endif

                if (eval_s) begin
                    if (state_q == ST_ACQUIRE) begin
                        acq_win_d = acq_next_s;
                        if (good_s) begin
                            good_run_d = good_next_s;
                        end else begin
                            good_run_d = 8'd0;
                        end
                        if (good_s && (good_next_s == 8'(LOCK_CNT))) begin
                            state_d   = ST_LOCKED;
                            lock_d    = 1'b1;
                            bad_run_d = 8'd0;
                        end else if (acq_next_s == 8'(ACQ_TIMEOUT)) begin
                            state_d  = ST_FAIL;
                            fail_d   = 1'b1;
                            lock_d   = 1'b0;
                            en_cp_d  = 1'b0;
                            en_vco_d = 1'b0;
                        end else begin
                            state_d = ST_ACQUIRE;
                        end
                    end else begin
                        if (good_s) begin
                            bad_run_d = 8'd0;
                        end else if (bad_next_s == 8'(UNLOCK_CNT)) begin
                            // The unlocking event already restarted the edge
                            // count, so the window stays open for reacquisition.
                            state_d    = ST_ACQUIRE;
                            lock_d     = 1'b0;
                            bad_run_d  = 8'd0;
                            good_run_d = 8'd0;
                            acq_win_d  = 8'd0;
                        end else begin
                            bad_run_d = bad_next_s;
                        end
                    end
                end else begin
                    state_d = state_q;
                end
            end

            ST_FAIL: begin
                state_d  = ST_FAIL;
                fail_d   = 1'b1;
                lock_d   = 1'b0;
                en_cp_d  = 1'b0;
                en_vco_d = 1'b0;
            end

            default: begin
                state_d  = ST_IDLE;
                lock_d   = 1'b0;
                fail_d   = 1'b0;
                en_cp_d  = 1'b0;
                en_vco_d = 1'b0;
            end
        endcase

        // Dropping START shuts the PLL down from any state; B and MEAS keep
        // their last values for diagnosis.
        if (!bus.START) begin
            state_d      = ST_IDLE;
            settle_cnt_d = 8'd0;
            edge_cnt_d   = 8'd0;
            good_run_d   = 8'd0;
            bad_run_d    = 8'd0;
            acq_win_d    = 8'd0;
            win_open_d   = 1'b0;
            b_d          = b_q;
            meas_d       = meas_q;
            lock_d       = 1'b0;
            fail_d       = 1'b0;
            en_cp_d      = 1'b0;
            en_vco_d     = 1'b0;
`ifdef AVSDPLL_REF_WATCHDOG_EN
            wd_cnt_d     = 12'd0;
`endif
        end else begin
            state_d = state_d;
        end
    end

    // State, counters, synchronizers and registered outputs.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q      <= ST_IDLE;
            settle_cnt_q <= 8'd0;
            edge_cnt_q   <= 8'd0;
            good_run_q   <= 8'd0;
            bad_run_q    <= 8'd0;
            acq_win_q    <= 8'd0;
            win_open_q   <= 1'b0;
            b_q          <= 4'd0;
            meas_q       <= 8'd0;
            lock_q       <= 1'b0;
            fail_q       <= 1'b0;
            en_cp_q      <= 1'b0;
            en_vco_q     <= 1'b0;
            ref_sync_q   <= 3'd0;
            pll_sync_q   <= 3'd0;
`ifdef AVSDPLL_REF_WATCHDOG_EN
            wd_cnt_q     <= 12'd0;
`endif
        end else begin
            state_q      <= state_d;
            settle_cnt_q <= settle_cnt_d;
            edge_cnt_q   <= edge_cnt_d;
            good_run_q   <= good_run_d;
            bad_run_q    <= bad_run_d;
            acq_win_q    <= acq_win_d;
            win_open_q   <= win_open_d;
            b_q          <= b_d;
            meas_q       <= meas_d;
            lock_q       <= lock_d;
            fail_q       <= fail_d;
            en_cp_q      <= en_cp_d;
            en_vco_q     <= en_vco_d;
            ref_sync_q   <= ref_sync_d;
            pll_sync_q   <= pll_sync_d;
`ifdef AVSDPLL_REF_WATCHDOG_EN
            wd_cnt_q     <= wd_cnt_d;
`endif
        end
    end

    assign bus.EN_CP  = en_cp_q;
    assign bus.EN_VCO = en_vco_q;
    assign bus.B      = b_q;
    assign bus.LOCK   = lock_q;
    assign bus.FAIL   = fail_q;
    assign bus.MEAS   = meas_q;
    assign bus.STATE  = state_q;

endmodule

// File: tb/tb_avsdpll_lock_ctrl.sv
// Self-checking bench for avsdpll_lock_ctrl. REF and PLL_CLK are generated
// as aligned periodic waves (k PLL periods per REF period), and a window-level
// model of the lock rules predicts the outputs in the middle of every window.
`timescale 1ns/1ps
module tb_avsdpll_lock_ctrl;

    logic CLK = 1'b0;
    logic RST;

    avsdpll_lock_ctrl_if bus();

    avsdpll_lock_ctrl dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    // window-level reference model
    int m_phase;   // 0 idle, 1 bring-up, 3 acquire, 4 locked, 5 fail
    int m_n;       // latched multiplication factor (also expected B)
    int m_meas;
    int m_gr, m_br, m_aw;
    bit m_open, m_lock, m_fail;
    int last_k;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic void model_reset();
        m_phase = 0; m_n = 0; m_meas = 0;
        m_gr = 0; m_br = 0; m_aw = 0;
        m_open = 0; m_lock = 0; m_fail = 0;
    endfunction

    function automatic void model_start(input int n);
        m_n = n; m_gr = 0; m_br = 0; m_aw = 0;
        m_open = 0; m_lock = 0; m_fail = 0;
        if (n == 0) begin
            m_phase = 5; m_fail = 1;
        end else begin
            m_phase = 1;
        end
    endfunction

    function automatic void model_stop();
        m_phase = 0; m_gr = 0; m_br = 0; m_aw = 0;
        m_open = 0; m_lock = 0; m_fail = 0;
    endfunction

    // A REF rise closing a window that contained kc PLL edges.
    function automatic void model_rise(input int kc);
        bit good;
        if (m_phase != 3 && m_phase != 4) return;
        if (!m_open) begin
            m_open = 1;
            return;
        end
        m_meas = (kc > 255) ? 255 : kc;
        good = ((kc - m_n) <= 1) && ((m_n - kc) <= 1);
        if (m_phase == 3) begin
            m_aw++;
            m_gr = good ? m_gr + 1 : 0;
            if (m_gr == 4) begin
                m_phase = 4; m_lock = 1; m_br = 0;
            end else if (m_aw == 64) begin
                m_phase = 5; m_fail = 1; m_lock = 0;
            end
        end else begin
            m_br = good ? 0 : m_br + 1;
            if (m_br == 2) begin
                m_phase = 3; m_lock = 0; m_gr = 0; m_aw = 0;
            end
        end
    endfunction

    task automatic check_outputs(input string tag);
        bit en;
        en = (m_phase == 3 || m_phase == 4);
        check_eq({tag, "/STATE"},  bus.STATE,  m_phase);
        check_eq({tag, "/LOCK"},   bus.LOCK,   m_lock);
        check_eq({tag, "/FAIL"},   bus.FAIL,   m_fail);
        check_eq({tag, "/EN_CP"},  bus.EN_CP,  en);
        check_eq({tag, "/EN_VCO"}, bus.EN_VCO, en);
        check_eq({tag, "/MEAS"},   bus.MEAS,   m_meas);
        check_eq({tag, "/B"},      bus.B,      m_n);
    endtask

    // One REF period holding k PLL periods of p CLK cycles each.
    task automatic run_window(input string tag, input int k, input int p,
                              input bit do_start, input int n);
        int r;
        bit bring;
        r = k * p;
        bring = 0;
        for (int c = 0; c < r; c++) begin
            @(negedge CLK);
            if (bring) begin
                if (c == 1 || c == 16) begin
                    check_eq({tag, "/bu_STATE"},  bus.STATE,  1);
                    check_eq({tag, "/bu_EN_CP"},  bus.EN_CP,  1);
                    check_eq({tag, "/bu_EN_VCO"}, bus.EN_VCO, 0);
                end
                if (c == 17 || c == 80) begin
                    check_eq({tag, "/bu_STATE"},  bus.STATE,  2);
                    check_eq({tag, "/bu_EN_VCO"}, bus.EN_VCO, 1);
                    check_eq({tag, "/bu_B"},      bus.B,      m_n);
                end
                if (c == 81) check_eq({tag, "/bu_STATE"}, bus.STATE, 3);
            end else if (c == r / 2) begin
                check_outputs(tag);
            end
            if (c == 0) begin
                model_rise(last_k);
                if (do_start) begin
                    bus.START   = 1'b1;
                    bus.DIV_SEL = 4'(n);
                    model_start(n);
                    bring = (n != 0);
                end
            end else if (c == 1) begin
                bus.DIV_SEL = 4'($urandom_range(0, 15));
            end
            bus.REF     = (c < r / 2);
            bus.PLL_CLK = ((c % p) < (p / 2));
        end
        last_k = k;
        if (m_phase == 1) begin
            m_phase = 3;
            m_open  = 0;
        end
    endtask

    task automatic stop_run(input string tag);
        @(negedge CLK);
        bus.START = 1'b0;
        @(negedge CLK);
        model_stop();
        check_outputs(tag);
    endtask

    task automatic pulse_reset(input string tag);
        #2 RST = 1'b1;
        #1;
        check_eq({tag, "/STATE"},  bus.STATE,  0);
        check_eq({tag, "/LOCK"},   bus.LOCK,   0);
        check_eq({tag, "/FAIL"},   bus.FAIL,   0);
        check_eq({tag, "/EN_CP"},  bus.EN_CP,  0);
        check_eq({tag, "/EN_VCO"}, bus.EN_VCO, 0);
        check_eq({tag, "/MEAS"},   bus.MEAS,   0);
        check_eq({tag, "/B"},      bus.B,      0);
        bus.START = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        model_reset();
    endtask

    // Time limit so a broken design can never hang the run.
    initial begin
        #5_000_000;
        $display("FAIL timeout: observed running expected finished");
        $fatal(1, "time limit");
    end

    initial begin
        int n, p, k;
        RST = 1'b1;
        bus.START = 1'b0; bus.DIV_SEL = 4'd0; bus.REF = 1'b0; bus.PLL_CLK = 1'b0;
        last_k = 0;
        model_reset();
        repeat (3) @(negedge CLK);
        check_outputs("reset");
        RST = 1'b0;

        // Bring-up and lock at N=8, 800-cycle REF, 100-cycle PLL_CLK.
        run_window("lock8", 8, 100, 1, 8);
        repeat (5) run_window("lock8", 8, 100, 0, 0);
        // Loss of lock: single bad window tolerated, two drop LOCK, then relock.
        run_window("unlk", 12, 20, 0, 0);
        run_window("unlk", 8, 20, 0, 0);
        run_window("unlk", 12, 20, 0, 0);
        run_window("unlk", 12, 20, 0, 0);
        repeat (5) run_window("relock", 8, 20, 0, 0);
        stop_run("stop_locked");

        // Tolerance edge: 9 edges for N=8 still locks.
        run_window("tol9", 9, 12, 1, 8);
        repeat (6) run_window("tol9", 9, 12, 0, 0);
        stop_run("stop_tol9");

        // 10 edges for N=8 never locks and times out into FAIL.
        run_window("tol10", 10, 12, 1, 8);
        repeat (66) run_window("tol10", 10, 12, 0, 0);
        stop_run("stop_fail");

        // Illegal divider.
        run_window("div0", 8, 12, 1, 0);
        run_window("div0", 8, 12, 0, 0);
        stop_run("stop_div0");

        // Randomized runs.
        for (int it = 0; it < 4; it++) begin
            n = $urandom_range(8, 12);
            p = $urandom_range(12, 16);
            run_window("rnd", n + $urandom_range(0, 2) - 1, p, 1, n);
            for (int w = 0; w < 14; w++) begin
                if ($urandom_range(0, 3) == 0)
                    k = ($urandom_range(0, 1) != 0) ? n + 2 : n - 2;
                else
                    k = n + $urandom_range(0, 2) - 1;
                run_window("rnd", k, p, 0, 0);
            end
            stop_run("stop_rnd");
        end

        // Asynchronous reset in the middle of acquisition.
        run_window("acq", 10, 12, 1, 10);
        repeat (2) run_window("acq", 10, 12, 0, 0);
        pulse_reset("rst_mid");

        // REF stops while locked.
        run_window("noref", 8, 12, 1, 8);
        repeat (5) run_window("noref", 8, 12, 0, 0);
        for (int c = 0; c < 8300; c++) begin
            @(negedge CLK);
            bus.REF     = 1'b0;
            bus.PLL_CLK = ((c % 12) < 6);
        end
        @(negedge CLK);
`ifdef AVSDPLL_REF_WATCHDOG_EN
        check_eq("wd/LOCK", bus.LOCK, 0);
        check_eq("wd/MEAS", bus.MEAS, 0);
        m_meas = 0;
`else
        check_outputs("noref_hold");
`endif
        stop_run("stop_noref");

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/avsdpll_lock_ctrl.md
Name: avsdpll_lock_ctrl

Overview:
- Bring-up sequencer and lock detector for the avsdpll macro; drives the PLL's EN_CP, EN_VCO and B inputs and observes its REF and CLK output.
- Counts PLL output edges per REF period, then asserts LOCK or FAIL.
- Sits in the digital domain next to the PLL and runs on the fast system clock; REF and PLL_CLK are sampled as asynchronous data.

Parameters:
- CP_SETTLE, 16: CLK cycles in CP_ON before the VCO is enabled.
- VCO_SETTLE, 64: CLK cycles in VCO_ON before measurement starts.
- TOL, 1: allowed deviation from the expected edge count per window.
- LOCK_CNT, 4: consecutive good windows required to assert LOCK.
- UNLOCK_CNT, 2: consecutive bad windows required to drop LOCK.
- ACQ_TIMEOUT, 64: windows allowed in ACQUIRE before FAIL.

Ports:
- CLK  input  1  system clock; must be at least 4x the PLL_CLK frequency.
- RST  input  1  asynchronous reset, active-high.
- START  input  1  level: high = run bring-up and monitor; low = shut the PLL down.
- DIV_SEL  input  4  expected multiplication N; latched on the IDLE->CP_ON transition.
- REF  input  1  PLL reference, asynchronous.
- PLL_CLK  input  1  PLL output (the macro's CLK pin), asynchronous.
- EN_CP  output  1  charge-pump enable to the PLL.
- EN_VCO  output  1  VCO enable to the PLL.
- B  output  4  divider select to the PLL, equal to the latched DIV_SEL.
- LOCK  output  1  PLL locked.
- FAIL  output  1  bring-up failed; sticky until START is low.
- MEAS  output  8  PLL_CLK edge count of the last closed window.
- STATE  output  3  FSM state encoding.

Behaviour:
- Reset: every output is 0, the FSM is in IDLE, all counters are 0 and the synchronizers are cleared.
- Synchronizers: REF and PLL_CLK each pass through 2 flops plus a history flop. A rise is detected in cycle k when s2=1 and s3=0.
- FSM states and encoding: IDLE=0, CP_ON=1, VCO_ON=2, ACQUIRE=3, LOCKED=4, FAIL=5.
- IDLE: when START=1, latch DIV_SEL into B.
  - If DIV_SEL=0, go to FAIL.
  - Otherwise go to CP_ON and set EN_CP=1 from the next cycle.
- CP_ON: after CP_SETTLE cycles, go to VCO_ON and set EN_VCO=1.
- VCO_ON: after VCO_SETTLE cycles, go to ACQUIRE.
- Windows:
  - In ACQUIRE and LOCKED, the edge counter increments on each PLL_CLK rise and saturates at 255.
  - A REF rise closes the current window: MEAS <= count at k+1, and the counter restarts.
  - A PLL_CLK rise in the same cycle as a REF rise counts into the new window (counter restarts at 1).
  - The first REF rise after entering ACQUIRE only opens a window: no evaluation, MEAS unchanged.
  - A window is good when |count - N| <= TOL. Compute at 9-bit signed width; no wrap.
- ACQUIRE:
  - Good windows increment good_run; a bad window clears it.
  - When good_run reaches LOCK_CNT, go to LOCKED and set LOCK=1 at k+1.
  - Each evaluated window increments acq_windows. After ACQ_TIMEOUT evaluated windows without lock, go to FAIL.
- LOCKED:
  - Bad windows increment bad_run; a good window clears it.
  - When bad_run reaches UNLOCK_CNT, set LOCK=0, go to ACQUIRE, and clear good_run and acq_windows.
  - EN_CP and EN_VCO stay high.
- FAIL: FAIL=1, EN_CP=0, EN_VCO=0, LOCK=0. Stays in FAIL while START=1.
- START=0 in any state: IDLE next cycle. EN_CP, EN_VCO, LOCK and FAIL go to 0 and counters clear; B and MEAS hold.
- Re-assertion of START restarts from CP_ON, with a fresh DIV_SEL latch.
- RST mid-operation: everything returns to reset values immediately, including B and MEAS.
- DIV_SEL changes after the latch are ignored until the next IDLE exit.

Optional Feature:
- Macro: AVSDPLL_REF_WATCHDOG_EN.
- With the macro defined: in ACQUIRE and LOCKED, a 12-bit counter counts CLK cycles since the last REF rise.
  - Reaching 4095 counts as one bad window: counter reload, MEAS <= 0, edge count restarted.
  - A dead REF therefore drops LOCK or leads to FAIL.
- Without the macro: no watchdog. A stopped REF freezes window evaluation, and LOCK/STATE hold indefinitely.

Test Plan:
- Bring-up and lock: START=1, DIV_SEL=8, REF period 800 CLK, PLL_CLK period 100 CLK.
  - Required: EN_CP rises 1 cycle after START; EN_VCO rises 16 cycles later.
  - Required: LOCK rises at the 4th evaluated window; MEAS=8; STATE=4.
- Tolerance edge: PLL_CLK period giving 9 edges per window -> LOCK asserts. Giving 10 edges per window -> never locks; FAIL=1 after 64 windows with EN_CP=EN_VCO=0.
- Loss of lock: after LOCK, switch to 12 edges/window.
  - One bad window then a good one -> LOCK stays 1.
  - Two consecutive bad windows -> LOCK=0, STATE=3.
  - Restoring 8 edges/window -> relock after 4 good windows.
- Illegal and abort:
  - DIV_SEL=0 with START=1 -> STATE=5, FAIL=1, enables never rise.
  - START=0 -> IDLE and FAIL=0 next cycle.
  - START=0 while locked -> LOCK/EN_VCO/EN_CP all 0 next cycle.
- Reset and simultaneity:
  - RST pulse mid-ACQUIRE -> all outputs 0 asynchronously.
  - REF and PLL_CLK rising in the same cycle -> that PLL edge counted in the new window (MEAS stays 8 at steady state).
- Watchdog (macro defined): stop REF while locked -> LOCK=0 after 2x4095 cycles, MEAS=0. Macro undefined -> LOCK stays 1.
